agc_ram_arbiter: RTL

//  Shares the single agc_ram instance between the AGC Core and a debug/loader port (bench

---
 rtl/agc_ram_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/agc_ram_arbiter.sv
// -----------------------------------------------------------------------------
// agc_ram_arbiter
//
// Shares the single agc_ram between the AGC Core and a debug/loader port.
// The Core owns the RAM by default. The debug port is served in cycles where
// the Core makes no RAM request or is halted. If the debug port has waited
// MAX_WAIT cycles, the arbiter steals one cycle by asserting stall to the Core.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   core_rd_en/_rd_addr   Core read request and address
//   core_wr_en/_wr_addr/
//   core_wr_data          Core write request, address and data
//   core_halt             Core halted; the RAM is free for debug
//   core_rdata            Core read data (RAM output, 1 cycle after request)
//   stall                 registered; the Core must hold its request
//   dbg_valid/_we/_addr/
//   dbg_wdata             debug request
//   dbg_ready             combinational grant to the debug port
//   dbg_rvalid/_rdata     debug read response, 1 cycle after a granted read
//   ram_*                 agc_ram interface (1-cycle registered read)
//   arb_state             current arbiter state, for observation
//
// Debug handshake: dbg_valid is raised with a stable request and held until
// dbg_ready. A transfer happens in every cycle where dbg_valid && dbg_ready.
// dbg_ready may depend combinationally on dbg_valid and the Core request.
// -----------------------------------------------------------------------------
module agc_ram_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 15,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_rd_en,
  input  logic [ADDR_W-1:0] core_rd_addr,
  input  logic              core_wr_en,
  input  logic [ADDR_W-1:0] core_wr_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  input  logic              core_halt,
  output logic [DATA_W-1:0] core_rdata,
  output logic              stall,
  input  logic              dbg_valid,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_rdaddress,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              arb_state
);

  typedef enum logic {
    OWN_CORE = 1'b0,
    STEAL    = 1'b1
  } state_t;

  localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             dbg_rvalid_q, dbg_rvalid_d;
  logic             grant;

  // Debug wins in a stolen cycle, while the Core is halted, or whenever the
  // Core makes no RAM request at all.
  assign grant = dbg_valid &
                 ((state_q == STEAL) | core_halt | (~core_rd_en & ~core_wr_en));

  // Next state, wait counter and read-valid.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    dbg_rvalid_d = grant & ~dbg_we;

    if (dbg_valid && !grant) begin
      if (wait_cnt_q != WAIT_LAST) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
    end

    case (state_q)
      OWN_CORE: begin
        if (dbg_valid && !grant && (wait_cnt_q == WAIT_LAST)) begin
          state_d = STEAL;
        end
      end
      STEAL: begin
        // One cycle only; the counter restarts so the Core always gets
        // at least MAX_WAIT-1 cycles before the next steal.
        state_d = OWN_CORE;
      end
      default: state_d = OWN_CORE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= OWN_CORE;
      wait_cnt_q   <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  // RAM mux. In a stolen cycle the Core's enables are ignored, so a dropped
  // debug request leaves the slot empty rather than letting a Core write in.
  always_comb begin
    ram_rdaddress = core_rd_addr;
    ram_wraddress = core_wr_addr;
    ram_data      = core_wr_data;
    ram_wren      = core_wr_en & (state_q != STEAL);
    if (grant) begin
      ram_rdaddress = dbg_addr;
      ram_wraddress = dbg_addr;
      ram_data      = dbg_wdata;
      ram_wren      = dbg_we;
    end
  end

  // The RAM read is registered, so data requested in cycle N is valid in N+1
  // for whoever asked, regardless of who owns the RAM in N+1.
  assign core_rdata = ram_q;
  assign dbg_rdata  = ram_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_ready  = grant;
  assign stall      = (state_q == STEAL);
  assign arb_state  = state_q;

endmodule
